// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit type, input port indices and a
// constant-foldable clog2 helper used to size pointers and VC tags.
package noc_pkg;

  localparam int unsigned DATASIZE = 40;

  typedef logic [DATASIZE-1:0] flit_t;

  // Input port order: N, E, S, L
  localparam int unsigned PORT_N = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_S = 2;
  localparam int unsigned PORT_L = 3;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_vc_sub.sv
// One virtual-channel FIFO, first-word-fall-through.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_wdata/i_wr_en write flit and request
//   i_rd_en         pop request (ignored when empty)
//   o_rdata         head flit, forced to 0 while empty
//   o_empty_n       FIFO holds at least one flit
//   o_full/o_afull  registered from the next-state count
//   o_count         occupancy 0..DEPTH
//   o_ovf/o_udf     single-cycle event: write dropped / pop on empty
import noc_pkg::*;

module fifo_vc_sub #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned DATASIZE     = noc_pkg::DATASIZE,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] i_wdata,
  input  logic                i_wr_en,
  input  logic                i_rd_en,
  output logic [DATASIZE-1:0] o_rdata,
  output logic                o_empty_n,
  output logic                o_full,
  output logic                o_afull,
  output logic [WIDTH:0]      o_count,
  output logic                o_ovf,
  output logic                o_udf
);

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0]    r_wptr;
  logic [WIDTH-1:0]    r_rptr;
  logic [WIDTH:0]      r_count;
  logic                r_full;
  logic                r_afull;

  logic                w_push;
  logic                w_pop;
  logic [WIDTH:0]      w_count_d;

  always_comb begin
    w_pop     = i_rd_en && (r_count != '0);
    // A full FIFO still takes a write when its head is popped the same edge
    w_push    = i_wr_en && (!r_full || w_pop);
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + (WIDTH+1)'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - (WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + WIDTH'(1);
      if (w_pop)  r_rptr <= r_rptr + WIDTH'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == (WIDTH+1)'(DEPTH));
      r_afull <= (w_count_d >= (WIDTH+1)'(AFULL_THRESH));
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_empty_n = (r_count != '0);
  assign o_rdata   = o_empty_n ? r_mem[r_rptr] : '0;
  assign o_full    = r_full;
  assign o_afull   = r_afull;
  assign o_count   = r_count;
  assign o_ovf     = i_wr_en && !w_push;
  assign o_udf     = i_rd_en && !o_empty_n;

endmodule

// File: rtl/fifo_bank_vc.sv
// Router input-buffer bank: NUM_PORTS input ports, each demuxed by a per-flit VC
// tag into NUM_VC FWFT FIFOs (Q = NUM_PORTS*NUM_VC, q = port*NUM_VC + vc).
// Ports:
//   fifo_clk, rst_n  clock, asynchronous active-low reset
//   in_data/in_valid/in_vc  per-port write flit, request and target VC
//   rd_en            per-VC pop request
//   err_clr          synchronous clear of sticky error flags
//   out_data/out_valid      per-VC head flit (0 when empty) and non-empty
//   full/afull/pressure     per-VC status and occupancy
//   err_ovf          sticky per port: a write was dropped
//   err_udf          sticky per VC: pop requested while empty
import noc_pkg::*;

module fifo_bank_vc #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned NUM_VC       = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned WIDTH        = noc_pkg::clog2(DEPTH),
  parameter int unsigned DATASIZE     = noc_pkg::DATASIZE,
  parameter int unsigned AFULL_THRESH = 6,
  parameter int unsigned VCW          = (NUM_VC > 1) ? noc_pkg::clog2(NUM_VC) : 1
) (
  input  logic                               fifo_clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS*DATASIZE-1:0]      in_data,
  input  logic [NUM_PORTS-1:0]               in_valid,
  input  logic [NUM_PORTS*VCW-1:0]           in_vc,
  input  logic [NUM_PORTS*NUM_VC-1:0]        rd_en,
  input  logic                               err_clr,
  output logic [NUM_PORTS*NUM_VC*DATASIZE-1:0]  out_data,
  output logic [NUM_PORTS*NUM_VC-1:0]        out_valid,
  output logic [NUM_PORTS*NUM_VC-1:0]        full,
  output logic [NUM_PORTS*NUM_VC-1:0]        afull,
  output logic [NUM_PORTS*NUM_VC*(WIDTH+1)-1:0] pressure,
  output logic [NUM_PORTS-1:0]               err_ovf,
  output logic [NUM_PORTS*NUM_VC-1:0]        err_udf
);

  localparam int unsigned Q = NUM_PORTS * NUM_VC;

  logic [VCW-1:0]       w_vc [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_bad_vc;
  logic [Q-1:0]         w_wr_en;
  logic [Q-1:0]         w_vc_ovf;
  logic [Q-1:0]         w_udf_evt;
  logic [NUM_PORTS-1:0] w_ovf_evt;
  logic [NUM_PORTS-1:0] r_err_ovf;
  logic [Q-1:0]         r_err_udf;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_vc[p]     = in_vc[p*VCW +: VCW];
    // Tags beyond NUM_VC (only possible when NUM_VC is not a power of two) are dropped
    assign w_bad_vc[p] = in_valid[p] && (32'(w_vc[p]) >= NUM_VC);
  end

  for (genvar q = 0; q < Q; q++) begin : g_vc
    localparam int unsigned P = q / NUM_VC;
    localparam int unsigned V = q % NUM_VC;

    assign w_wr_en[q] = in_valid[P] && (32'(w_vc[P]) == V);

    fifo_vc_sub #(
      .DEPTH        (DEPTH),
      .WIDTH        (WIDTH),
      .DATASIZE     (DATASIZE),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_fifo (
      .clk       (fifo_clk),
      .rst_n     (rst_n),
      .i_wdata   (in_data[P*DATASIZE +: DATASIZE]),
      .i_wr_en   (w_wr_en[q]),
      .i_rd_en   (rd_en[q]),
      .o_rdata   (out_data[q*DATASIZE +: DATASIZE]),
      .o_empty_n (out_valid[q]),
      .o_full    (full[q]),
      .o_afull   (afull[q]),
      .o_count   (pressure[q*(WIDTH+1) +: WIDTH+1]),
      .o_ovf     (w_vc_ovf[q]),
      .o_udf     (w_udf_evt[q])
    );
  end

  always_comb begin
    w_ovf_evt = w_bad_vc;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        w_ovf_evt[p] = w_ovf_evt[p] | w_vc_ovf[p*NUM_VC + v];
      end
    end
  end

  // A new error event outranks a clear in the same cycle
  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= '0;
      r_err_udf <= '0;
    end else begin
      r_err_ovf <= (r_err_ovf & ~{NUM_PORTS{err_clr}}) | w_ovf_evt;
      r_err_udf <= (r_err_udf & ~{Q{err_clr}}) | w_udf_evt;
    end
  end

  assign err_ovf = r_err_ovf;
  assign err_udf = r_err_udf;

endmodule

// File: tb/tb_fifo_bank_vc.sv
module tb_fifo_bank_vc;
  import noc_pkg::*;

  localparam int Q  = 8;
  localparam int DW = 40;
  localparam int PW = 4;

  logic              fifo_clk;
  logic              rst_n;
  logic [4*DW-1:0]   in_data;
  logic [3:0]        in_valid;
  logic [3:0]        in_vc;
  logic [Q-1:0]      rd_en;
  logic              err_clr;
  logic [Q*DW-1:0]   out_data;
  logic [Q-1:0]      out_valid;
  logic [Q-1:0]      full;
  logic [Q-1:0]      afull;
  logic [Q*PW-1:0]   pressure;
  logic [3:0]        err_ovf;
  logic [Q-1:0]      err_udf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] sb [Q][$];

  fifo_bank_vc dut (
    .fifo_clk  (fifo_clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_vc     (in_vc),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .full      (full),
    .afull     (afull),
    .pressure  (pressure),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  function automatic logic [DW-1:0] od(input int q);
    return out_data[q*DW +: DW];
  endfunction

  function automatic logic [PW-1:0] pr(input int q);
    return pressure[q*PW +: PW];
  endfunction

  task automatic tick();
    @(posedge fifo_clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    in_vc    = '0;
    in_data  = '0;
    rd_en    = '0;
    err_clr  = 1'b0;
  endtask

  task automatic drive_push(input int p, input int v, input logic [DW-1:0] d);
    in_valid[p]         = 1'b1;
    in_vc[p]            = v[0];
    in_data[p*DW +: DW] = d;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset_valid got %h exp 0", out_valid); end
    n_checks++; if (full !== '0)      begin n_fail++; $display("FAIL reset_full got %h exp 0", full); end
    n_checks++; if (afull !== '0)     begin n_fail++; $display("FAIL reset_afull got %h exp 0", afull); end
    n_checks++; if (pressure !== '0)  begin n_fail++; $display("FAIL reset_pressure got %h exp 0", pressure); end
    n_checks++; if (out_data !== '0)  begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
    n_checks++; if (err_ovf !== '0 || err_udf !== '0) begin
      n_fail++; $display("FAIL reset_err got %h/%h exp 0/0", err_ovf, err_udf);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwft();
    idle();
    drive_push(PORT_N, 1, 40'hA1);
    tick();
    idle();
    n_checks++; if (out_valid !== 8'b0000_0010) begin n_fail++; $display("FAIL fwft_valid got %b exp 00000010", out_valid); end
    n_checks++; if (od(1) !== 40'hA1) begin n_fail++; $display("FAIL fwft_data got %h exp a1", od(1)); end
    n_checks++; if (od(0) !== 40'h0)  begin n_fail++; $display("FAIL fwft_mask got %h exp 0", od(0)); end
    n_checks++; if (pressure !== 32'h0000_0010) begin n_fail++; $display("FAIL fwft_pressure got %h exp 00000010", pressure); end
    rd_en[1] = 1'b1;
    tick();
    idle();
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL fwft_pop got %b exp 0", out_valid); end
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= 8; i++) begin
      idle();
      drive_push(PORT_S, 0, 40'(i));
      tick();
      n_checks++; if (afull[4] !== (i >= 6)) begin n_fail++; $display("FAIL afull_%0d got %b exp %b", i, afull[4], i >= 6); end
      n_checks++; if (full[4] !== (i == 8))  begin n_fail++; $display("FAIL full_%0d got %b exp %b", i, full[4], i == 8); end
      n_checks++; if (pr(4) !== 4'(i))       begin n_fail++; $display("FAIL press_%0d got %0d exp %0d", i, pr(4), i); end
    end
    idle();
    drive_push(PORT_S, 0, 40'h9);
    tick();
    idle();
    n_checks++; if (err_ovf !== 4'b0100) begin n_fail++; $display("FAIL ovf_flag got %b exp 0100", err_ovf); end
    n_checks++; if (pr(4) !== 4'd8)      begin n_fail++; $display("FAIL ovf_press got %0d exp 8", pr(4)); end
    n_checks++; if (od(4) !== 40'h1)     begin n_fail++; $display("FAIL ovf_head got %h exp 1", od(4)); end
  endtask

  task automatic test_push_pop_full();
    logic [DW-1:0] exp_d;
    idle();
    err_clr = 1'b1;
    tick();
    idle();
    n_checks++; if (err_ovf !== '0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", err_ovf); end
    drive_push(PORT_S, 0, 40'h99);
    rd_en[4] = 1'b1;
    tick();
    idle();
    n_checks++; if (pr(4) !== 4'd8)  begin n_fail++; $display("FAIL pp_press got %0d exp 8", pr(4)); end
    n_checks++; if (full[4] !== 1'b1) begin n_fail++; $display("FAIL pp_full got %b exp 1", full[4]); end
    n_checks++; if (err_ovf !== '0)  begin n_fail++; $display("FAIL pp_ovf got %b exp 0", err_ovf); end
    for (int k = 0; k < 8; k++) begin
      exp_d = (k < 7) ? 40'(k + 2) : 40'h99;
      n_checks++; if (od(4) !== exp_d) begin n_fail++; $display("FAIL drain_%0d got %h exp %h", k, od(4), exp_d); end
      rd_en[4] = 1'b1;
      tick();
      idle();
    end
    n_checks++; if (pr(4) !== 4'd0 || out_valid[4] !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty got %0d/%b exp 0/0", pr(4), out_valid[4]);
    end
    n_checks++; if (err_udf !== '0) begin n_fail++; $display("FAIL drain_udf got %b exp 0", err_udf); end
  endtask

  task automatic test_underflow();
    idle();
    rd_en[5] = 1'b1;
    tick();
    idle();
    n_checks++; if (err_udf !== 8'b0010_0000) begin n_fail++; $display("FAIL udf_flag got %b exp 00100000", err_udf); end
    n_checks++; if (pr(5) !== 4'd0 || out_valid[5] !== 1'b0) begin
      n_fail++; $display("FAIL udf_state got %0d/%b exp 0/0", pr(5), out_valid[5]);
    end
    err_clr  = 1'b1;
    rd_en[5] = 1'b1;
    tick();
    idle();
    n_checks++; if (err_udf !== 8'b0010_0000) begin n_fail++; $display("FAIL udf_win got %b exp 00100000", err_udf); end
    err_clr = 1'b1;
    tick();
    idle();
    n_checks++; if (err_udf !== '0) begin n_fail++; $display("FAIL udf_clr got %b exp 0", err_udf); end
  endtask

  task automatic test_interleave();
    int q;
    for (int it = 0; it < 20; it++) begin
      idle();
      for (int p = 0; p < 4; p++) begin
        if ((it + p) % 4 != 3) drive_push(p, (it + p) % 2, {8'(p), 8'(it), 24'hC0FFEE});
      end
      for (int k = 0; k < Q; k++) begin
        if (sb[k].size() > 0 && (it + k) % 3 == 0) rd_en[k] = 1'b1;
      end
      for (int k = 0; k < Q; k++) begin
        n_checks++; if (out_valid[k] !== (sb[k].size() != 0)) begin
          n_fail++; $display("FAIL il_valid it%0d q%0d got %b exp %b", it, k, out_valid[k], sb[k].size() != 0);
        end
        if (sb[k].size() > 0) begin
          n_checks++; if (od(k) !== sb[k][0]) begin
            n_fail++; $display("FAIL il_data it%0d q%0d got %h exp %h", it, k, od(k), sb[k][0]);
          end
        end
      end
      tick();
      for (int k = 0; k < Q; k++) if (rd_en[k]) void'(sb[k].pop_front());
      for (int p = 0; p < 4; p++) begin
        if (in_valid[p]) begin
          q = p * 2 + int'(in_vc[p]);
          if (sb[q].size() < 8) sb[q].push_back(in_data[p*DW +: DW]);
        end
      end
    end
    for (int it = 0; it < 12; it++) begin
      idle();
      for (int k = 0; k < Q; k++) begin
        if (sb[k].size() > 0) begin
          rd_en[k] = 1'b1;
          n_checks++; if (od(k) !== sb[k][0]) begin
            n_fail++; $display("FAIL il_drain it%0d q%0d got %h exp %h", it, k, od(k), sb[k][0]);
          end
        end
      end
      if (rd_en == '0) break;
      tick();
      for (int k = 0; k < Q; k++) if (rd_en[k]) void'(sb[k].pop_front());
    end
    idle();
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL il_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      idle();
      drive_push(PORT_E, 1, 40'(8'h30 + i));
      tick();
    end
    idle();
    n_checks++; if (afull[3] !== 1'b1 || pr(3) !== 4'd6) begin
      n_fail++; $display("FAIL mid_pre got %b/%0d exp 1/6", afull[3], pr(3));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== '0 || full !== '0 || afull !== '0) begin
      n_fail++; $display("FAIL mid_flags got %b/%b/%b exp 0/0/0", out_valid, full, afull);
    end
    n_checks++; if (pressure !== '0 || out_data !== '0) begin
      n_fail++; $display("FAIL mid_state got %h/%h exp 0/0", pressure, out_data);
    end
    tick();
    rst_n = 1'b1;
    drive_push(PORT_E, 1, 40'h55);
    tick();
    idle();
    n_checks++; if (od(3) !== 40'h55 || pr(3) !== 4'd1) begin
      n_fail++; $display("FAIL mid_head got %h/%0d exp 55/1", od(3), pr(3));
    end
    n_checks++; if (out_valid !== 8'b0000_1000) begin n_fail++; $display("FAIL mid_valid got %b exp 00001000", out_valid); end
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    test_reset();
    test_fwft();
    test_full_overflow();
    test_push_pop_full();
    test_underflow();
    test_interleave();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
